// File: rtl/button_debounce.sv
// ============================================================================
// Module   : button_debounce
// Brief    : Push-button synchroniser and debouncer with Press/Release pulses
//            and an optional long-press pulse (enabled by BTN_LONG_PRESS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce #(
    parameter int DB_CYCLES = 1000000,
    parameter int LP_CYCLES = 100000000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic BTN,
    output logic Level,
    output logic Press,
    output logic Release,
    output logic LongPress
);

    localparam int          c_CNT_W   = 27;
    localparam int          c_CNT_MAX = 134217727;
    localparam logic [26:0] c_DB_LAST = 27'(DB_CYCLES - 1);

    generate
        if (DB_CYCLES < 1 || DB_CYCLES > c_CNT_MAX ||
            LP_CYCLES < 1 || LP_CYCLES > c_CNT_MAX) begin : g_bad_params
            $error("button_debounce: DB_CYCLES/LP_CYCLES outside 1..2^27-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_db_cnt;
    logic               r_sync1;
    logic               r_btn_s;
    logic               r_level;
    logic               r_press;
    logic               r_release;

    logic w_db_done;
    logic w_press_next;
    logic w_release_next;

    assign w_db_done      = (r_db_cnt == c_DB_LAST);
    assign w_press_next   = (r_state == PRESS_WAIT)   &&  r_btn_s && w_db_done;
    assign w_release_next = (r_state == RELEASE_WAIT) && !r_btn_s && w_db_done;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_db_cnt  <= '0;
            r_sync1   <= 1'b0;
            r_btn_s   <= 1'b0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= BTN;
            r_btn_s   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_level <= 1'b0;
                    if (r_btn_s) begin
                        r_state  <= PRESS_WAIT;
                        r_db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_btn_s) begin
                        r_state <= IDLE;
                    end else if (w_db_done) begin
                        r_state <= HELD;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 27'd1;
                    end
                end
                HELD: begin
                    if (!r_btn_s) begin
                        r_state  <= RELEASE_WAIT;
                        r_db_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back high rejoins HELD; the window restarts on re-entry.
                    if (r_btn_s) begin
                        r_state <= HELD;
                    end else if (w_db_done) begin
                        r_state   <= IDLE;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 27'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Level   = r_level;
    assign Press   = r_press;
    assign Release = r_release;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [26:0] c_LP_MAX  = 27'(LP_CYCLES);
    localparam logic [26:0] c_LP_LAST = 27'(LP_CYCLES - 1);

    logic [c_CNT_W-1:0] r_hold_cnt;
    logic               r_long;

    // Counter saturates at LP_CYCLES so the pulse can fire only once per press.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hold_cnt <= '0;
            r_long     <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_press_next) begin
                r_hold_cnt <= '0;
            end else if (r_state == HELD || r_state == RELEASE_WAIT) begin
                if (r_hold_cnt != c_LP_MAX) begin
                    r_hold_cnt <= r_hold_cnt + 27'd1;
                end
                if (r_hold_cnt == c_LP_LAST && !w_release_next) begin
                    r_long <= 1'b1;
                end
            end
        end
    end

    assign LongPress = r_long;
`else
    assign LongPress = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
// ============================================================================
// Module   : tb_button_debounce
// Brief    : Directed scoreboard bench for button_debounce (DB=4, LP=20).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debounce;

    localparam int c_DB = 4;
    localparam int c_LP = 20;
`ifdef BTN_LONG_PRESS_EN
    localparam bit c_LP_EN = 1'b1;
`else
    localparam bit c_LP_EN = 1'b0;
`endif

    logic Clk;
    logic Reset;
    logic BTN;
    logic Level;
    logic Press;
    logic Release;
    logic LongPress;

    button_debounce #(
        .DB_CYCLES (c_DB),
        .LP_CYCLES (c_LP)
    ) u_dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .BTN       (BTN),
        .Level     (Level),
        .Press     (Press),
        .Release   (Release),
        .LongPress (LongPress)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic  lvl;
        logic  prs;
        logic  rel;
        logic  lng;
        string tag;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Drive BTN for n edges. ev_at = edge (1-based) at which Level toggles and
    // Press/Release pulses (0 = none); lp_at = edge of LongPress (0 = none).
    task automatic seg(input logic btn, input int n, input int ev_at,
                       input logic lvl0, input int lp_at, input string tag);
        exp_t e;
        exp_t got;
        for (int i = 1; i <= n; i++) begin
            e.lvl = (ev_at != 0 && i >= ev_at) ? ~lvl0 : lvl0;
            e.prs = (i == ev_at) && !lvl0;
            e.rel = (i == ev_at) && lvl0;
            e.lng = (i == lp_at) && c_LP_EN;
            e.tag = $sformatf("%s[%0d]", tag, i);
            q_exp.push_back(e);
            BTN = btn;
            @(posedge Clk);
            #1;
            got = q_exp.pop_front();
            chk({got.tag, ".Level"},     Level,     got.lvl);
            chk({got.tag, ".Press"},     Press,     got.prs);
            chk({got.tag, ".Release"},   Release,   got.rel);
            chk({got.tag, ".LongPress"}, LongPress, got.lng);
        end
    endtask

    initial begin
        Reset = 1'b1;
        BTN   = 1'b0;

        seg(1'b0, 5, 0, 1'b0, 0, "reset");
        Reset = 1'b0;
        seg(1'b0, 5, 0, 1'b0, 0, "post_reset");

        // Press: Level/Press at edge DB+3 = 7; held 40 cycles after Press,
        // LongPress 20 cycles after Press (edge 27 -> 17th edge of 2nd segment).
        seg(1'b1, 10, c_DB + 3, 1'b0, 0, "press");
        seg(1'b1, 37, 0, 1'b1, 27 - 10, "hold");
        seg(1'b0, 10, c_DB + 3, 1'b1, 0, "release");

        // Bounce: high 3, low 1, ten times -> never accepted.
        for (int k = 0; k < 10; k++) begin
            seg(1'b1, 3, 0, 1'b0, 0, $sformatf("bounce%0d_hi", k));
            seg(1'b0, 1, 0, 1'b0, 0, $sformatf("bounce%0d_lo", k));
        end
        seg(1'b0, 6, 0, 1'b0, 0, "bounce_settle");

        // Glitch while HELD: low 2, high 1, then low stable -> Release at 7.
        seg(1'b1, 10, c_DB + 3, 1'b0, 0, "g_press");
        seg(1'b0, 2, 0, 1'b1, 0, "g_low");
        seg(1'b1, 1, 0, 1'b1, 0, "g_high");
        seg(1'b0, 10, c_DB + 3, 1'b1, 0, "g_release");

        // Reset while HELD: Level drops, no pulses; held button is a new press.
        seg(1'b1, 10, c_DB + 3, 1'b0, 0, "r_press");
        Reset = 1'b1;
        seg(1'b1, 1, 0, 1'b0, 0, "r_reset");
        Reset = 1'b0;
        seg(1'b1, 10, c_DB + 3, 1'b0, 0, "r_repress");
        seg(1'b1, 25, 0, 1'b1, 27 - 10, "r_hold");
        seg(1'b0, 10, c_DB + 3, 1'b1, 0, "r_release");
        seg(1'b0, 5, 0, 1'b0, 0, "final_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
